ibus_responder: RTL and testbench
=================================

# ibus_responder

Instruction-bus responder: the memory-side end of the core's fetch handshake. The core drives `valid`/`addr` and holds them until `data_ok`; this block accepts the request, waits a configurable latency, and returns one 32-bit instruction word from an internal word array. It replaces the ideal instruction memory in simulation and in the single-core test top. A preload port fills the array before or during a run.

## Interface
- `BASE_ADDR`, 64'h8000_0000: byte address of word 0.
- `DEPTH_LOG2`, 12: the array holds 2^DEPTH_LOG2 32-bit words.
- `LATENCY`, 2: cycles from accept to `data_ok`. Legal range 1..15.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous reset, active-low.
- `req_valid`  in  1: fetch request valid.
- `req_addr`  in  64: byte address of the requested instruction.
- `resp_addr_ok`  out  1: request accepted this cycle (combinational).
- `resp_data_ok`  out  1: response valid this cycle; high for exactly one cycle per request.
- `resp_data`  out  32: instruction word; meaningful only while `resp_data_ok` is high.
- `resp_err`  out  1: the response is for a misaligned or out-of-range address; meaningful only with `resp_data_ok`.
- `load_en`  in  1: preload write enable.
- `load_idx`  in  DEPTH_LOG2: word index to write.
- `load_data`  in  32: word to write.

## Operation
- There are three states: IDLE, WAIT, RESP.
- **IDLE**
  - `resp_addr_ok` = `req_valid`.
  - On `req_valid`, latch `req_addr` and decode it:
    - offset = `req_addr` − `BASE_ADDR`, 64-bit unsigned with wrap.
    - Error if `req_addr[1:0]` ≠ 0, or if offset ≥ 4·2^DEPTH_LOG2.
    - Word index = offset[DEPTH_LOG2+1:2].
  - Load count = `LATENCY`−1.
  - If count = 0, go to RESP; otherwise go to WAIT.
- **WAIT**
  - Decrement count each cycle. At 0, go to RESP.
  - `req_addr` and `req_valid` are ignored; the latched address is authoritative.
- **Entering RESP**, on the same edge:
  - Register `resp_data` = array[index] using pre-edge contents, or 0 on error.
  - Register `resp_err`.
  - Set `resp_data_ok` = 1.
- **RESP**
  - Lasts one cycle, with `resp_addr_ok` = 0.
  - Next state is IDLE, where `resp_data_ok` returns to 0.
  - No request is accepted in RESP: the core's address is still the stalled PC in this cycle.
- **Preload**
  - When `load_en` is high, array[`load_idx`] ← `load_data` at the edge.
  - This is independent of the state machine.
  - A write that coincides with the RESP-entry read returns the old word.
- **Reset**
  - Asynchronous assertion forces IDLE, count 0, `resp_data_ok` 0, `resp_data` 0, `resp_err` 0.
  - Array contents are not reset.
  - Reset during WAIT or RESP drops the in-flight request; no `data_ok` is produced for it.
- `resp_data` and `resp_err` hold their last values outside RESP. Consumers must qualify them with `resp_data_ok`.

## Timing
- Request accepted in cycle T (IDLE, `req_valid`=1): `resp_data_ok` is high in cycle T+`LATENCY` only.
- Earliest next accept is T+`LATENCY`+1. Throughput is one word per `LATENCY`+1 cycles with `req_valid` held high.
- `resp_addr_ok` is combinational from `req_valid` and state. All other outputs are registered.
- First accept is possible in the first cycle after reset deasserts, provided `req_valid`=1.
- `req_valid` low in IDLE: stay in IDLE with all outputs idle.

## Test plan
- **Reset:** hold `reset` low for 3 cycles with `req_valid`=1 → `resp_addr_ok`, `resp_data_ok`, `resp_data`, `resp_err` all 0 throughout. First accept occurs in the cycle after release.
- **Basic fetch (LATENCY=2):**
  - Stimulus: preload idx 0 = 32'h0000_0413, idx 1 = 32'h0010_0493; hold `req_valid`=1, `req_addr`=0x8000_0000 from cycle T.
  - Required: `resp_addr_ok` at T; `data_ok` with 0x0000_0413 at T+2, `err`=0; no `data_ok` at T+3.
  - Then switch `req_addr` to 0x8000_0004 at T+3 → accept at T+3; `data_ok` with 0x0010_0493 at T+5.
- **LATENCY=1 sweep:** 8 sequential addresses from 0x8000_0000 → 8 responses exactly 2 cycles apart, data matching preload.
- **Errors:**
  - `req_addr`=0x8000_0002 → `data_ok`, `err`=1, data 0.
  - `req_addr`=0x8000_4000 (DEPTH_LOG2=12) → `err`=1.
  - `req_addr`=0x7FFF_FFFC → `err`=1 (wrap makes the offset huge).
- **Request change mid-WAIT:** accept 0x8000_0000, then change `req_addr` to 0x8000_0004 during WAIT → response carries the idx 0 word.
- **Mid-operation events:**
  - Reset asserted during WAIT → no `data_ok` ever appears for that request.
  - Preload idx 0 = 32'hDEAD_BEEF on the RESP-entry edge of an idx 0 fetch → old word returned. A refetch then returns 32'hDEAD_BEEF.

Source files
------------

// File: rtl/ibus_if.sv
// Instruction-fetch handshake between the core (master) and the
// instruction-side memory responder (slave).
//   req_valid    : core -> mem, fetch request valid, held until resp_data_ok
//   req_addr     : core -> mem, 64-bit byte address of the instruction
//   resp_addr_ok : mem -> core, request accepted this cycle
//   resp_data_ok : mem -> core, one-cycle pulse, resp_data/resp_err valid
//   resp_data    : mem -> core, 32-bit instruction word
//   resp_err     : mem -> core, misaligned or out-of-range fetch
interface ibus_if;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        resp_addr_ok;
  logic        resp_data_ok;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, req_addr,
    input  resp_addr_ok, resp_data_ok, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr,
    output resp_addr_ok, resp_data_ok, resp_data, resp_err
  );
endinterface

// File: rtl/ibus_responder.sv
// Instruction-bus responder: accepts one fetch in IDLE, waits LATENCY cycles
// and returns one word from an internal array (or an error for a misaligned
// or out-of-range address). A preload port writes the array at any time.
//   clk       : single clock, rising edge
//   reset     : asynchronous reset, active-low
//   bus       : fetch handshake (slave side of ibus_if)
//   load_en   : preload write enable
//   load_idx  : preload word index
//   load_data : preload word
module ibus_responder #(
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2   // legal 1..15
) (
  input  logic                  clk,
  input  logic                  reset,
  ibus_if.slave                 bus,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_idx,
  input  logic [31:0]           load_data
);

  localparam int          DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [63:0] SPAN     = 64'd4 << DEPTH_LOG2;  // bytes covered
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;    // latched word index
  logic                  aerr_q, aerr_d;  // latched decode error
  logic                  data_ok_q;
  logic [31:0]           data_q;
  logic                  err_q;

  logic [31:0]           mem [DEPTH];

  // Live decode of the incoming address; only used on the accept cycle.
  // The subtraction wraps, so addresses below BASE_ADDR land far above SPAN.
  logic [63:0]           offset;
  logic                  dec_err;
  logic [DEPTH_LOG2-1:0] dec_idx;

  assign offset  = bus.req_addr - BASE_ADDR;
  assign dec_err = (bus.req_addr[1:0] != 2'b00) || (offset >= SPAN);
  assign dec_idx = offset[DEPTH_LOG2+1:2];

  // Read port selection for the RESP-entry edge: with LATENCY=1 the entry
  // edge is the accept edge, so the live decode is used instead of the latch.
  logic                  enter_resp;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_err;
  logic                  addr_ok;

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    aerr_d     = aerr_q;
    enter_resp = 1'b0;
    rd_idx     = idx_q;
    rd_err     = aerr_q;
    addr_ok    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Gated by reset so nothing is accepted while reset is held.
        addr_ok = bus.req_valid && reset;
        if (bus.req_valid) begin
          idx_d  = dec_idx;
          aerr_d = dec_err;
          cnt_d  = CNT_INIT;
          if (CNT_INIT == 4'd0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
            rd_idx     = dec_idx;
            rd_err     = dec_err;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Request inputs are ignored here; the latched decode is authoritative.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      aerr_q    <= 1'b0;
      data_ok_q <= 1'b0;
      data_q    <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so the array read below sees the
      // pre-edge contents even when a preload hits the same word this edge.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      aerr_q    <= aerr_d;
      data_ok_q <= enter_resp;
      if (enter_resp) begin
        data_q <= rd_err ? 32'd0 : mem[rd_idx];
        err_q  <= rd_err;
      end
    end
  end

  // NOTE: the array has no reset; its contents come only from the preload port.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_idx] <= load_data;
    end
  end

  assign bus.resp_addr_ok = addr_ok;
  assign bus.resp_data_ok = data_ok_q;
  assign bus.resp_data    = data_q;
  assign bus.resp_err     = err_q;

endmodule

// File: tb/tb_ibus_responder.sv
module tb_ibus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [11:0] load_idx;
  logic [31:0] load_data;

  int total = 0;
  int bad   = 0;

  ibus_if bus2 ();
  ibus_if bus1 ();

  ibus_responder #(.BASE_ADDR(64'h8000_0000), .DEPTH_LOG2(12), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .bus(bus2),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data)
  );

  ibus_responder #(.BASE_ADDR(64'h8000_0000), .DEPTH_LOG2(12), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .bus(bus1),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] idx;
    logic [31:0] data;
  } pre_t;

  typedef struct {
    string       name;
    logic [63:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;

  pre_t pre [9];
  vec_t tbl [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle2(input string name);
    check({name, ".aok"},  64'(bus2.resp_addr_ok), 64'd0);
    check({name, ".dok"},  64'(bus2.resp_data_ok), 64'd0);
    check({name, ".data"}, 64'(bus2.resp_data),    64'd0);
    check({name, ".err"},  64'(bus2.resp_err),     64'd0);
  endtask

  // Single LATENCY=2 fetch starting in IDLE: accept at T, response at T+2,
  // nothing at T+1 or T+3. Leaves the DUT in IDLE with req_valid low.
  task automatic fetch2(input string name, input logic [63:0] addr,
                        input logic [31:0] exp_data, input logic exp_err);
    bus2.req_valid = 1'b1;
    bus2.req_addr  = addr;
    #1;
    check({name, ".accept"}, 64'(bus2.resp_addr_ok), 64'd1);
    tick();
    bus2.req_valid = 1'b0;
    #1;
    check({name, ".t1_dok"}, 64'(bus2.resp_data_ok), 64'd0);
    tick();
    #1;
    check({name, ".t2_dok"},  64'(bus2.resp_data_ok), 64'd1);
    check({name, ".t2_data"}, 64'(bus2.resp_data),    64'(exp_data));
    check({name, ".t2_err"},  64'(bus2.resp_err),     64'(exp_err));
    tick();
    #1;
    check({name, ".t3_dok"}, 64'(bus2.resp_data_ok), 64'd0);
  endtask

  initial begin
    pre[0] = '{12'd0,   32'h0000_0413};
    pre[1] = '{12'd1,   32'h0010_0493};
    pre[2] = '{12'd2,   32'h0020_0513};
    pre[3] = '{12'd3,   32'h0030_0593};
    pre[4] = '{12'd4,   32'h0040_0613};
    pre[5] = '{12'd5,   32'h0050_0693};
    pre[6] = '{12'd6,   32'h0060_0713};
    pre[7] = '{12'd7,   32'h0070_0793};
    pre[8] = '{12'hFFF, 32'hCAFE_F00D};

    tbl[0] = '{"w0",     64'h0000_0000_8000_0000, 32'h0000_0413, 1'b0};
    tbl[1] = '{"w5",     64'h0000_0000_8000_0014, 32'h0050_0693, 1'b0};
    tbl[2] = '{"w7",     64'h0000_0000_8000_001C, 32'h0070_0793, 1'b0};
    tbl[3] = '{"last",   64'h0000_0000_8000_3FFC, 32'hCAFE_F00D, 1'b0};
    tbl[4] = '{"mis2",   64'h0000_0000_8000_0002, 32'h0000_0000, 1'b1};
    tbl[5] = '{"mis1",   64'h0000_0000_8000_0005, 32'h0000_0000, 1'b1};
    tbl[6] = '{"oor",    64'h0000_0000_8000_4000, 32'h0000_0000, 1'b1};
    tbl[7] = '{"wrap",   64'h0000_0000_7FFF_FFFC, 32'h0000_0000, 1'b1};
    tbl[8] = '{"hi",     64'h0000_0001_8000_0000, 32'h0000_0000, 1'b1};

    reset          = 1'b0;
    load_en        = 1'b0;
    load_idx       = '0;
    load_data      = '0;
    bus2.req_valid = 1'b1;
    bus2.req_addr  = 64'h8000_0000;
    bus1.req_valid = 1'b1;
    bus1.req_addr  = 64'h8000_0000;

    // Reset held with req_valid high; preload happens meanwhile.
    for (int i = 0; i < 9; i++) begin
      tick();
      load_en   = 1'b1;
      load_idx  = pre[i].idx;
      load_data = pre[i].data;
      #1;
      check_idle2("rst");
      check("rst.aok1", 64'(bus1.resp_addr_ok), 64'd0);
      check("rst.dok1", 64'(bus1.resp_data_ok), 64'd0);
    end
    tick();
    load_en = 1'b0;
    #1;
    check_idle2("rst_end");

    // Release: first accept in the cycle right after, with basic fetch.
    tick();
    reset          = 1'b1;
    bus1.req_valid = 1'b0;
    #1;
    check("basic.T_aok", 64'(bus2.resp_addr_ok), 64'd1);
    tick(); #1;
    check("basic.T1_aok", 64'(bus2.resp_addr_ok), 64'd0);
    check("basic.T1_dok", 64'(bus2.resp_data_ok), 64'd0);
    tick(); #1;
    check("basic.T2_dok",  64'(bus2.resp_data_ok), 64'd1);
    check("basic.T2_data", 64'(bus2.resp_data),    64'h0000_0413);
    check("basic.T2_err",  64'(bus2.resp_err),     64'd0);
    check("basic.T2_aok",  64'(bus2.resp_addr_ok), 64'd0);
    tick();
    bus2.req_addr = 64'h8000_0004;
    #1;
    check("basic.T3_dok", 64'(bus2.resp_data_ok), 64'd0);
    check("basic.T3_aok", 64'(bus2.resp_addr_ok), 64'd1);
    tick(); #1;
    check("basic.T4_dok", 64'(bus2.resp_data_ok), 64'd0);
    tick(); #1;
    check("basic.T5_dok",  64'(bus2.resp_data_ok), 64'd1);
    check("basic.T5_data", 64'(bus2.resp_data),    64'h0010_0493);
    check("basic.T5_err",  64'(bus2.resp_err),     64'd0);
    tick();
    bus2.req_valid = 1'b0;
    #1;
    check("basic.T6_dok", 64'(bus2.resp_data_ok), 64'd0);
    check("basic.T6_aok", 64'(bus2.resp_addr_ok), 64'd0);

    // Table of single fetches including error and boundary addresses.
    for (int i = 0; i < 9; i++) begin
      tick();
      fetch2(tbl[i].name, tbl[i].addr, tbl[i].data, tbl[i].err);
    end

    // LATENCY=1: eight back-to-back fetches, one response every 2 cycles.
    for (int i = 0; i < 8; i++) begin
      tick();
      bus1.req_valid = 1'b1;
      bus1.req_addr  = 64'h8000_0000 + 64'(4 * i);
      #1;
      check($sformatf("sweep%0d.aok", i), 64'(bus1.resp_addr_ok), 64'd1);
      check($sformatf("sweep%0d.dok0", i), 64'(bus1.resp_data_ok), 64'd0);
      tick(); #1;
      check($sformatf("sweep%0d.dok", i), 64'(bus1.resp_data_ok), 64'd1);
      check($sformatf("sweep%0d.data", i), 64'(bus1.resp_data), 64'(pre[i].data));
      check($sformatf("sweep%0d.aok_resp", i), 64'(bus1.resp_addr_ok), 64'd0);
    end
    tick();
    bus1.req_valid = 1'b0;
    #1;
    check("sweep.end_dok", 64'(bus1.resp_data_ok), 64'd0);

    // Address changes during WAIT must not affect the response.
    tick();
    bus2.req_valid = 1'b1;
    bus2.req_addr  = 64'h8000_0000;
    #1;
    check("midwait.aok", 64'(bus2.resp_addr_ok), 64'd1);
    tick();
    bus2.req_addr = 64'h8000_0004;
    #1;
    check("midwait.T1_aok", 64'(bus2.resp_addr_ok), 64'd0);
    tick();
    bus2.req_valid = 1'b0;
    #1;
    check("midwait.dok",  64'(bus2.resp_data_ok), 64'd1);
    check("midwait.data", 64'(bus2.resp_data),    64'h0000_0413);

    // Reset asserted during WAIT drops the request.
    tick(); tick();
    bus2.req_valid = 1'b1;
    bus2.req_addr  = 64'h8000_0004;
    #1;
    check("rstwait.aok", 64'(bus2.resp_addr_ok), 64'd1);
    tick();
    bus2.req_valid = 1'b0;
    reset          = 1'b0;
    #1;
    check_idle2("rstwait.asserted");
    tick();
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rstwait.after%0d", i), 64'(bus2.resp_data_ok), 64'd0);
      tick();
    end

    // Preload on the RESP-entry edge returns the old word; refetch the new.
    bus2.req_valid = 1'b1;
    bus2.req_addr  = 64'h8000_0000;
    #1;
    check("coll.aok", 64'(bus2.resp_addr_ok), 64'd1);
    tick();
    bus2.req_valid = 1'b0;
    load_en        = 1'b1;
    load_idx       = 12'd0;
    load_data      = 32'hDEAD_BEEF;
    tick();
    load_en = 1'b0;
    #1;
    check("coll.dok",  64'(bus2.resp_data_ok), 64'd1);
    check("coll.data", 64'(bus2.resp_data),    64'h0000_0413);
    tick();
    fetch2("refetch", 64'h8000_0000, 32'hDEAD_BEEF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
